// File: rtl/gnn_bias_pkg.sv
// Shared definitions for the GNN bias-load engine: instruction layout, line geometry,
// FSM encodings and small decode helpers.
package gnn_bias_pkg;

  localparam int unsigned INST_W            = 96;
  localparam int unsigned FIELD_W           = 16;
  localparam int unsigned BUF_AW            = 9;
  localparam int unsigned LINE_BYTES        = 64;
  localparam int unsigned LINE_SHIFT        = 6;
  localparam int unsigned INST_DRAM_OFS_LSB = 80;
  localparam int unsigned INST_LINES_LSB    = 48;
  localparam int unsigned INST_BUF_ADDR_LSB = 32;
  localparam int unsigned MAX_BURST_BEATS   = 64;
  localparam int unsigned BURST_STRIDE      = MAX_BURST_BEATS * LINE_BYTES;
  localparam int unsigned STATE_W           = 2;

  typedef logic [STATE_W-1:0] bias_state_t;

  localparam bias_state_t ST_IDLE  = 2'd0;
  localparam bias_state_t ST_ISSUE = 2'd1;
  localparam bias_state_t ST_LOAD  = 2'd2;
  localparam bias_state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic [FIELD_W-1:0] dram_ofs;
    logic [FIELD_W-1:0] lines;
    logic [BUF_AW-1:0]  buf_addr;
  } bias_inst_t;

  // Pull the used fields out of a bias instruction; reserved bits are dropped here.
  function automatic bias_inst_t decode_inst(input logic [INST_W-1:0] inst);
    bias_inst_t d;
    d.dram_ofs = inst[INST_DRAM_OFS_LSB +: FIELD_W];
    d.lines    = inst[INST_LINES_LSB +: FIELD_W];
    d.buf_addr = inst[INST_BUF_ADDR_LSB +: BUF_AW];
    return d;
  endfunction

  // Beats carried by the next burst given the beats still outstanding.
  function automatic logic [FIELD_W-1:0] burst_beats(input logic [FIELD_W-1:0] remain);
    return (remain > FIELD_W'(MAX_BURST_BEATS)) ? FIELD_W'(MAX_BURST_BEATS) : remain;
  endfunction

endpackage

// File: rtl/gnn_bias_axi_rd_master.sv
// Minimal AXI read master: splits a line transfer into bursts of up to 64 beats
// and forwards the R channel as a plain valid/data stream.
module gnn_bias_axi_rd_master
  import gnn_bias_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512
) (
  input  logic               kernel_clk,
  input  logic               kernel_rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [FIELD_W-1:0] total_beats,
  input  logic               rd_ready,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  output logic [ADDR_W-1:0]  m_axi_araddr,
  output logic [7:0]         m_axi_arlen,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready,
  input  logic [DATA_W-1:0]  m_axi_rdata,
  input  logic               m_axi_rlast,
  output logic               stream_valid_c,
  output logic [DATA_W-1:0]  stream_data_c
);

  localparam logic M_IDLE = 1'b0;
  localparam logic M_ADDR = 1'b1;

  logic               state_q, state_d;
  logic [FIELD_W-1:0] remain_q, remain_d;
  logic [ADDR_W-1:0]  araddr_d;
  logic [7:0]         arlen_d;
  logic               arvalid_d;
  logic [FIELD_W-1:0] rem_after_c;
  logic               unused_ok;

  // Address-phase state register.
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      state_q       <= M_IDLE;
      remain_q      <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
    end else begin
      state_q       <= state_d;
      remain_q      <= remain_d;
      m_axi_araddr  <= araddr_d;
      m_axi_arlen   <= arlen_d;
      m_axi_arvalid <= arvalid_d;
    end
  end

  // Burst issue: one AR per accepted handshake until all beats are requested.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    araddr_d    = m_axi_araddr;
    arlen_d     = m_axi_arlen;
    arvalid_d   = m_axi_arvalid;
    rem_after_c = remain_q - burst_beats(remain_q);
    case (state_q)
      M_IDLE: begin
        if (start && (total_beats != '0)) begin
          araddr_d  = start_addr;
          remain_d  = total_beats;
          arlen_d   = 8'(burst_beats(total_beats) - FIELD_W'(1));
          arvalid_d = 1'b1;
          state_d   = M_ADDR;
        end
      end
      default: begin
        if (m_axi_arvalid && m_axi_arready) begin
          remain_d = rem_after_c;
          araddr_d = m_axi_araddr + ADDR_W'(BURST_STRIDE);
          if (rem_after_c != '0) begin
            arlen_d = 8'(burst_beats(rem_after_c) - FIELD_W'(1));
          end else begin
            arvalid_d = 1'b0;
            state_d   = M_IDLE;
          end
        end
      end
    endcase
  end

  assign m_axi_rready   = rd_ready;
  assign stream_valid_c = m_axi_rvalid;
  assign stream_data_c  = m_axi_rdata;
  assign unused_ok      = m_axi_rlast;

endmodule

// File: rtl/gnn_0_example_bias.sv
// GNN bias-load engine: decodes a bias instruction, requests N DRAM lines and writes
// the returned beats to the bias buffer. Build option: GNN_BIAS_AXI_MASTER_EN.
module gnn_0_example_bias
  import gnn_bias_pkg::*;
#(
  parameter int unsigned BIAS_INST_LENGTH   = 96,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
  parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
  parameter int unsigned C_ADDER_BIT_WIDTH  = 32
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst,
  input  logic                          aclk,
  input  logic                          areset,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,
  output logic                          bias_write_buffer_b_valid,
  output logic [BUF_AW-1:0]             bias_write_buffer_b_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] bias_write_buffer_b_data,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [BIAS_INST_LENGTH-1:0]   ctrl_instruction,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
  output logic                          read_start,
  output logic                          read_done,
  input  logic                          data_tvalid,
  output logic                          data_tready,
  input  logic                          data_tlast,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata
);

  localparam int unsigned ADDR_W         = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DATA_W         = C_M_AXI_DATA_WIDTH;
  localparam int unsigned XFER_W         = C_XFER_SIZE_WIDTH;
  localparam int unsigned ADDER_W_UNUSED = C_ADDER_BIT_WIDTH;

  bias_state_t        state_q, state_d;
  bias_inst_t         inst_dec_c;
  logic [FIELD_W-1:0] lines_q, lines_d;
  logic [FIELD_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BUF_AW-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]  xfer_addr_d;
  logic [XFER_W-1:0]  xfer_size_d;
  logic               read_start_d, read_done_d, ap_done_d, tready_d;
  logic               b_valid_d;
  logic [BUF_AW-1:0]  b_addr_d;
  logic [DATA_W-1:0]  b_data_d;
  logic               stream_valid_c;
  logic [DATA_W-1:0]  stream_data_c;
  logic               unused_ok;

  assign inst_dec_c = decode_inst(ctrl_instruction);

  // State and registered outputs.
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      state_q                   <= ST_IDLE;
      lines_q                   <= '0;
      beat_cnt_q                <= '0;
      wr_addr_q                 <= '0;
      dram_xfer_start_addr      <= '0;
      dram_xfer_size_in_bytes   <= '0;
      read_start                <= 1'b0;
      read_done                 <= 1'b0;
      ap_done                   <= 1'b0;
      data_tready               <= 1'b0;
      bias_write_buffer_b_valid <= 1'b0;
      bias_write_buffer_b_addr  <= '0;
      bias_write_buffer_b_data  <= '0;
    end else begin
      state_q                   <= state_d;
      lines_q                   <= lines_d;
      beat_cnt_q                <= beat_cnt_d;
      wr_addr_q                 <= wr_addr_d;
      dram_xfer_start_addr      <= xfer_addr_d;
      dram_xfer_size_in_bytes   <= xfer_size_d;
      read_start                <= read_start_d;
      read_done                 <= read_done_d;
      ap_done                   <= ap_done_d;
      data_tready               <= tready_d;
      bias_write_buffer_b_valid <= b_valid_d;
      bias_write_buffer_b_addr  <= b_addr_d;
      bias_write_buffer_b_data  <= b_data_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    lines_d      = lines_q;
    beat_cnt_d   = beat_cnt_q;
    wr_addr_d    = wr_addr_q;
    xfer_addr_d  = dram_xfer_start_addr;
    xfer_size_d  = dram_xfer_size_in_bytes;
    read_done_d  = 1'b0;
    ap_done_d    = 1'b0;
    b_valid_d    = 1'b0;
    b_addr_d     = bias_write_buffer_b_addr;
    b_data_d     = bias_write_buffer_b_data;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          lines_d     = inst_dec_c.lines;
          beat_cnt_d  = '0;
          wr_addr_d   = inst_dec_c.buf_addr;
          xfer_addr_d = ctrl_addr_offset + (ADDR_W'(inst_dec_c.dram_ofs) << LINE_SHIFT);
          xfer_size_d = XFER_W'(inst_dec_c.lines) << LINE_SHIFT;
          state_d     = (inst_dec_c.lines == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_LOAD;
      ST_LOAD: begin
        // No backpressure: every valid cycle is a beat and lands in the buffer.
        if (stream_valid_c) begin
          b_valid_d  = 1'b1;
          b_addr_d   = wr_addr_q;
          b_data_d   = stream_data_c;
          wr_addr_d  = wr_addr_q + BUF_AW'(1);
          beat_cnt_d = beat_cnt_q + FIELD_W'(1);
          if (beat_cnt_q == lines_q - FIELD_W'(1)) begin
            read_done_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      default: begin
        ap_done_d = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
    read_start_d = (state_d == ST_ISSUE);
    tready_d     = (state_d == ST_LOAD);
  end

`ifdef GNN_BIAS_AXI_MASTER_EN
  gnn_bias_axi_rd_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_axi_rd_master (
    .kernel_clk     (kernel_clk),
    .kernel_rst     (kernel_rst),
    .start          (read_start),
    .start_addr     (dram_xfer_start_addr),
    .total_beats    (lines_q),
    .rd_ready       (data_tready),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rlast    (m_axi_rlast),
    .stream_valid_c (stream_valid_c),
    .stream_data_c  (stream_data_c)
  );

  assign unused_ok = ^{aclk, areset, data_tvalid, data_tlast, data_tdata,
                       ctrl_instruction[79:64], ctrl_instruction[47:41],
                       ctrl_instruction[31:0], ADDER_W_UNUSED};
`else
  assign m_axi_arvalid  = 1'b0;
  assign m_axi_araddr   = '0;
  assign m_axi_arlen    = '0;
  assign m_axi_rready   = 1'b0;
  assign stream_valid_c = data_tvalid;
  assign stream_data_c  = data_tdata;

  assign unused_ok = ^{aclk, areset, data_tlast, m_axi_arready, m_axi_rvalid,
                       m_axi_rdata, m_axi_rlast, ctrl_instruction[79:64],
                       ctrl_instruction[47:41], ctrl_instruction[31:0], ADDER_W_UNUSED};
`endif

endmodule

// File: tb/tb_gnn_0_example_bias.sv
// Bench for the bias-load engine: randomized stream source with gaps and junk beats,
// compared against a transfer-level model of the expected buffer writes and handshakes.
module tb_gnn_0_example_bias;

  logic         kernel_clk = 1'b0;
  logic         kernel_rst = 1'b1;
  logic         ap_start = 1'b0;
  logic [63:0]  ctrl_addr_offset = '0;
  logic [95:0]  ctrl_instruction = '0;
  logic         data_tvalid = 1'b0;
  logic         data_tlast = 1'b0;
  logic [511:0] data_tdata = '0;
  logic         m_axi_arvalid, m_axi_rready, bias_write_buffer_b_valid;
  logic [63:0]  m_axi_araddr, dram_xfer_start_addr;
  logic [7:0]   m_axi_arlen;
  logic [8:0]   bias_write_buffer_b_addr;
  logic [511:0] bias_write_buffer_b_data;
  logic         ap_done, read_start, read_done, data_tready;
  logic [31:0]  dram_xfer_size_in_bytes;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Observations of one transfer, filled by run_xfer and judged by each test.
  int           obs_rs_cnt, obs_rs_cyc, obs_rd_cnt, obs_rd_cyc, obs_ad_cnt, obs_ad_cyc, obs_wr_last;
  logic [63:0]  obs_addr;
  logic [31:0]  obs_size;
  bit           obs_hold_err, obs_timeout, obs_rst_zero;
  int           obs_post_rst_wr;
  logic [8:0]   obs_wa[$];
  logic [511:0] obs_wd[$];
  logic [511:0] sent_d[$];

  always #5 kernel_clk = ~kernel_clk;

  gnn_0_example_bias dut (
    .kernel_clk                (kernel_clk),
    .kernel_rst                (kernel_rst),
    .aclk                      (kernel_clk),
    .areset                    (1'b0),
    .m_axi_arvalid             (m_axi_arvalid),
    .m_axi_arready             (1'b0),
    .m_axi_araddr              (m_axi_araddr),
    .m_axi_arlen               (m_axi_arlen),
    .m_axi_rvalid              (1'b0),
    .m_axi_rready              (m_axi_rready),
    .m_axi_rdata               ('0),
    .m_axi_rlast               (1'b0),
    .bias_write_buffer_b_valid (bias_write_buffer_b_valid),
    .bias_write_buffer_b_addr  (bias_write_buffer_b_addr),
    .bias_write_buffer_b_data  (bias_write_buffer_b_data),
    .ap_start                  (ap_start),
    .ap_done                   (ap_done),
    .ctrl_addr_offset          (ctrl_addr_offset),
    .ctrl_instruction          (ctrl_instruction),
    .dram_xfer_start_addr      (dram_xfer_start_addr),
    .dram_xfer_size_in_bytes   (dram_xfer_size_in_bytes),
    .read_start                (read_start),
    .read_done                 (read_done),
    .data_tvalid               (data_tvalid),
    .data_tready               (data_tready),
    .data_tlast                (data_tlast),
    .data_tdata                (data_tdata)
  );

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge kernel_clk);
    #1;
  endtask

  function automatic bit outs_zero();
    return ({read_start, read_done, ap_done, bias_write_buffer_b_valid, data_tready} == 5'b0) &&
           (bias_write_buffer_b_addr == 9'd0) && (bias_write_buffer_b_data == '0) &&
           (dram_xfer_start_addr == 64'd0) && (dram_xfer_size_in_bytes == 32'd0);
  endfunction

  // Issue one instruction, act as the stream source, and record what the DUT does.
  // Cycle 0 is the ap_start cycle; data is decimal (n - k) when desc, random otherwise.
  task automatic run_xfer(input logic [15:0] ofs, input logic [15:0] n, input logic [15:0] badr,
                          input logic [63:0] base, input bit desc, input int inj_cyc,
                          input int abort_beats);
    int cyc, acc, post;
    bit done_seen;
    obs_rs_cnt = 0; obs_rd_cnt = 0; obs_ad_cnt = 0; obs_rs_cyc = -1; obs_rd_cyc = -1;
    obs_ad_cyc = -1; obs_wr_last = -1; obs_hold_err = 0; obs_timeout = 0; obs_rst_zero = 0;
    obs_post_rst_wr = 0; obs_addr = '0; obs_size = '0;
    obs_wa.delete(); obs_wd.delete(); sent_d.delete();
    cyc = 0; acc = 0; post = 0; done_seen = 0;
    ctrl_addr_offset = base;
    ctrl_instruction = {ofs, 16'($urandom), n, badr, 32'($urandom)};
    ap_start = 1'b1;
    data_tvalid = 1'($urandom_range(0, 1));
    data_tdata = rand512();
    while (1) begin
      step();
      cyc++;
      if (read_start) begin
        obs_rs_cnt++; obs_rs_cyc = cyc; obs_addr = dram_xfer_start_addr; obs_size = dram_xfer_size_in_bytes;
      end else if (obs_rs_cnt > 0 && (dram_xfer_start_addr !== obs_addr || dram_xfer_size_in_bytes !== obs_size)) begin
        obs_hold_err = 1;
      end
      if (bias_write_buffer_b_valid) begin
        obs_wa.push_back(bias_write_buffer_b_addr); obs_wd.push_back(bias_write_buffer_b_data); obs_wr_last = cyc;
      end
      if (read_done) begin obs_rd_cnt++; obs_rd_cyc = cyc; end
      if (ap_done) begin obs_ad_cnt++; obs_ad_cyc = cyc; done_seen = 1; end
      if (abort_beats > 0 && acc == abort_beats) begin
        data_tvalid = 1'b0;
        #2 kernel_rst = 1'b1;
        #1 obs_rst_zero = outs_zero();
        step();
        kernel_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
          step();
          if (ap_done) obs_ad_cnt++;
          if (read_done) obs_rd_cnt++;
          if (bias_write_buffer_b_valid) obs_post_rst_wr++;
        end
        break;
      end
      if (done_seen) begin
        post++;
        if (post > 4) break;
      end
      if (cyc > 3000) begin obs_timeout = 1; break; end
      ap_start = (cyc == inj_cyc);
      ctrl_instruction = {96{1'b0}} | {$urandom, $urandom, $urandom};
      ctrl_instruction[63:48] = 16'($urandom_range(1, 20));
      ctrl_addr_offset = {$urandom, $urandom};
      data_tlast = 1'($urandom_range(0, 1));
      if (data_tready) begin
        if (acc < int'(n) && $urandom_range(0, 99) < 75) begin
          data_tvalid = 1'b1;
          data_tdata = desc ? 512'(int'(n) - acc) : rand512();
          sent_d.push_back(data_tdata);
          acc++;
        end else begin
          data_tvalid = 1'b0;
          data_tdata = rand512();
        end
      end else begin
        data_tvalid = 1'($urandom_range(0, 1));
        data_tdata = rand512();
      end
    end
    ap_start = 1'b0;
    data_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    kernel_rst = 1'b1;
    #3;
    if (outs_zero() !== 1'b1) begin
      miscompares++; $display("FAIL reset_outputs got=%b exp=1", outs_zero());
    end
    vectors++;
    if ({m_axi_arvalid, m_axi_rready, m_axi_araddr, m_axi_arlen} !== '0) begin
      miscompares++; $display("FAIL reset_axi got=%b/%b/%h/%h exp=0", m_axi_arvalid, m_axi_rready, m_axi_araddr, m_axi_arlen);
    end
    vectors++;
    step(); step();
    kernel_rst = 1'b0;
    step();
    if (outs_zero() !== 1'b1) begin
      miscompares++; $display("FAIL idle_outputs got=%b exp=1", outs_zero());
    end
    vectors++;
  endtask

  task automatic test_spec_vectors();
    logic [63:0] exp_addr[2];
    logic [31:0] exp_size[2];
    int          exp_n[2], exp_base[2];
    exp_addr = '{64'd8192, 64'd65536}; exp_size = '{32'd128, 32'd1024};
    exp_n = '{2, 16}; exp_base = '{0, 12};
    for (int t = 0; t < 2; t++) begin
      if (t == 0) run_xfer(16'd128, 16'd2, 16'd0, 64'd0, 1'b1, -1, 0);
      else begin
        repeat (11) step();
        run_xfer(16'd1024, 16'd16, 16'd12, 64'd0, 1'b1, -1, 0);
      end
      if (obs_rs_cnt !== 1 || obs_rs_cyc !== 1) begin
        miscompares++; $display("FAIL spec%0d read_start got=%0d@%0d exp=1@1", t, obs_rs_cnt, obs_rs_cyc);
      end
      vectors++;
      if (obs_addr !== exp_addr[t] || obs_size !== exp_size[t]) begin
        miscompares++; $display("FAIL spec%0d xfer got=%0d/%0d exp=%0d/%0d", t, obs_addr, obs_size, exp_addr[t], exp_size[t]);
      end
      vectors++;
      if (obs_wa.size() !== exp_n[t]) begin
        miscompares++; $display("FAIL spec%0d write_count got=%0d exp=%0d", t, obs_wa.size(), exp_n[t]);
      end
      vectors++;
      for (int k = 0; k < obs_wa.size() && k < exp_n[t]; k++) begin
        if (obs_wa[k] !== 9'(exp_base[t] + k) || obs_wd[k] !== 512'(exp_n[t] - k)) begin
          miscompares++; $display("FAIL spec%0d write%0d got=%0d:%0d exp=%0d:%0d", t, k, obs_wa[k], obs_wd[k], exp_base[t] + k, exp_n[t] - k);
        end
        vectors++;
      end
      if (obs_rd_cnt !== 1 || obs_rd_cyc !== obs_wr_last || obs_ad_cnt !== 1 || obs_ad_cyc !== obs_wr_last + 1) begin
        miscompares++; $display("FAIL spec%0d done_timing got=rd%0d@%0d ad%0d@%0d exp=rd1@%0d ad1@%0d", t, obs_rd_cnt, obs_rd_cyc, obs_ad_cnt, obs_ad_cyc, obs_wr_last, obs_wr_last + 1);
      end
      vectors++;
      if (obs_hold_err !== 1'b0 || obs_timeout !== 1'b0) begin
        miscompares++; $display("FAIL spec%0d hold_or_timeout got=%b/%b exp=0/0", t, obs_hold_err, obs_timeout);
      end
      vectors++;
    end
  endtask

  task automatic test_zero_len();
    run_xfer(16'($urandom), 16'd0, 16'($urandom), {$urandom, $urandom}, 1'b0, -1, 0);
    if (obs_rs_cnt !== 0 || obs_wa.size() !== 0 || obs_rd_cnt !== 0) begin
      miscompares++; $display("FAIL zero_len activity got=rs%0d wr%0d rd%0d exp=0/0/0", obs_rs_cnt, obs_wa.size(), obs_rd_cnt);
    end
    vectors++;
    if (obs_ad_cnt !== 1 || obs_ad_cyc !== 2) begin
      miscompares++; $display("FAIL zero_len ap_done got=%0d@%0d exp=1@2", obs_ad_cnt, obs_ad_cyc);
    end
    vectors++;
  endtask

  task automatic test_random();
    logic [15:0] ofs, n, badr;
    logic [63:0] base;
    for (int it = 0; it < 15; it++) begin
      ofs = 16'($urandom); n = 16'($urandom_range(1, 40)); badr = 16'($urandom);
      base = {$urandom, $urandom};
      run_xfer(ofs, n, badr, base, 1'b0, -1, 0);
      if (obs_rs_cnt !== 1 || obs_addr !== base + 64'(ofs) * 64 || obs_size !== 32'(n) * 64) begin
        miscompares++; $display("FAIL rand%0d xfer got=%0d %h/%0d exp=1 %h/%0d", it, obs_rs_cnt, obs_addr, obs_size, base + 64'(ofs) * 64, 32'(n) * 64);
      end
      vectors++;
      if (obs_wa.size() !== int'(n) || sent_d.size() !== int'(n)) begin
        miscompares++; $display("FAIL rand%0d write_count got=%0d exp=%0d", it, obs_wa.size(), n);
      end
      vectors++;
      for (int k = 0; k < obs_wa.size() && k < sent_d.size(); k++) begin
        if (obs_wa[k] !== 9'(int'(badr[8:0]) + k) || obs_wd[k] !== sent_d[k]) begin
          miscompares++; $display("FAIL rand%0d write%0d got_addr=%0d exp_addr=%0d data_ok=%b", it, k, obs_wa[k], 9'(int'(badr[8:0]) + k), obs_wd[k] === sent_d[k]);
        end
        vectors++;
      end
      if (obs_rd_cyc !== obs_wr_last || obs_ad_cnt !== 1 || obs_ad_cyc !== obs_wr_last + 1 || obs_hold_err || obs_timeout) begin
        miscompares++; $display("FAIL rand%0d completion got=rd@%0d ad%0d@%0d hold%b to%b exp=rd@%0d ad1@%0d", it, obs_rd_cyc, obs_ad_cnt, obs_ad_cyc, obs_hold_err, obs_timeout, obs_wr_last, obs_wr_last + 1);
      end
      vectors++;
    end
  endtask

  task automatic test_ignore_start();
    run_xfer(16'd7, 16'd8, 16'd100, 64'h1000, 1'b1, 4, 0);
    if (obs_rs_cnt !== 1 || obs_addr !== 64'h1000 + 64'd448 || obs_size !== 32'd512 || obs_hold_err) begin
      miscompares++; $display("FAIL ignore_start xfer got=%0d %0d/%0d hold%b exp=1 %0d/512", obs_rs_cnt, obs_addr, obs_size, obs_hold_err, 64'h1000 + 64'd448);
    end
    vectors++;
    if (obs_wa.size() !== 8) begin
      miscompares++; $display("FAIL ignore_start write_count got=%0d exp=8", obs_wa.size());
    end
    vectors++;
    for (int k = 0; k < obs_wa.size() && k < 8; k++) begin
      if (obs_wa[k] !== 9'(100 + k) || obs_wd[k] !== 512'(8 - k)) begin
        miscompares++; $display("FAIL ignore_start write%0d got=%0d:%0d exp=%0d:%0d", k, obs_wa[k], obs_wd[k], 100 + k, 8 - k);
      end
      vectors++;
    end
    if (obs_ad_cnt !== 1) begin
      miscompares++; $display("FAIL ignore_start ap_done_count got=%0d exp=1", obs_ad_cnt);
    end
    vectors++;
  endtask

  task automatic test_wrap();
    logic [8:0] exp_wa[4];
    exp_wa = '{9'd510, 9'd511, 9'd0, 9'd1};
    run_xfer(16'd3, 16'd4, 16'd510, 64'd0, 1'b1, -1, 0);
    if (obs_wa.size() !== 4) begin
      miscompares++; $display("FAIL wrap write_count got=%0d exp=4", obs_wa.size());
    end
    vectors++;
    for (int k = 0; k < obs_wa.size() && k < 4; k++) begin
      if (obs_wa[k] !== exp_wa[k] || obs_wd[k] !== 512'(4 - k)) begin
        miscompares++; $display("FAIL wrap write%0d got=%0d:%0d exp=%0d:%0d", k, obs_wa[k], obs_wd[k], exp_wa[k], 4 - k);
      end
      vectors++;
    end
  endtask

  task automatic test_reset_mid();
    run_xfer(16'd5, 16'd10, 16'd40, 64'd0, 1'b0, -1, 3);
    if (obs_rst_zero !== 1'b1) begin
      miscompares++; $display("FAIL reset_mid outputs_zero got=%b exp=1", obs_rst_zero);
    end
    vectors++;
    if (obs_ad_cnt !== 0 || obs_rd_cnt !== 0 || obs_post_rst_wr !== 0) begin
      miscompares++; $display("FAIL reset_mid aborted got=ad%0d rd%0d wr%0d exp=0/0/0", obs_ad_cnt, obs_rd_cnt, obs_post_rst_wr);
    end
    vectors++;
    run_xfer(16'd2, 16'd3, 16'd7, 64'd64, 1'b1, -1, 0);
    if (obs_addr !== 64'd192 || obs_wa.size() !== 3 || obs_ad_cnt !== 1) begin
      miscompares++; $display("FAIL reset_mid recovery got=%0d wr%0d ad%0d exp=192 wr3 ad1", obs_addr, obs_wa.size(), obs_ad_cnt);
    end
    vectors++;
    for (int k = 0; k < obs_wa.size() && k < 3; k++) begin
      if (obs_wa[k] !== 9'(7 + k) || obs_wd[k] !== 512'(3 - k)) begin
        miscompares++; $display("FAIL reset_mid write%0d got=%0d:%0d exp=%0d:%0d", k, obs_wa[k], obs_wd[k], 7 + k, 3 - k);
      end
      vectors++;
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    repeat (3) step();
    test_zero_len();
    test_random();
    test_ignore_start();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
